// File: rtl/fp_mult_lanes_pipe_pkg.sv
// fp_mult_lanes_pipe_pkg: status bit indices and encoding helpers shared by the lane multiplier
package fp_mult_lanes_pipe_pkg;
    localparam int ST_W   = 4;
    localparam int ST_INV = 0;
    localparam int ST_OVF = 1;
    localparam int ST_UNF = 2;
    localparam int ST_INX = 3;
    function automatic int fp_bias(int ew);
        return (1 << (ew - 1)) - 1;
    endfunction
    function automatic logic [63:0] fp_inf(int sw, int ew, logic s);
        return (64'(s) << (sw + ew)) | (((64'd1 << ew) - 64'd1) << sw);
    endfunction
    function automatic logic [63:0] fp_nan(int sw, int ew);
        return fp_inf(sw, ew, 1'b0) | (64'd1 << (sw - 1));
    endfunction
endpackage

// File: rtl/fp_mult_lane.sv
// fp_mult_lane: one multiplier lane; unpack and multiply into stage-1 registers,
// then normalise, round and pack combinationally from those registers.
module fp_mult_lane
    import fp_mult_lanes_pipe_pkg::*;
#(
    parameter int SIG_WIDTH = 23,
    parameter int EXP_WIDTH = 8,
    parameter int RND_RNE   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [SIG_WIDTH+EXP_WIDTH:0] a,
    input  logic [SIG_WIDTH+EXP_WIDTH:0] b,
    output logic [SIG_WIDTH+EXP_WIDTH:0] z,
    output logic [ST_W-1:0]              status
);
    localparam int S  = SIG_WIDTH;
    localparam int E  = EXP_WIDTH;
    localparam int W  = S + E + 1;
    localparam int PW = 2 * S + 2;
    logic [E-1:0] ea, eb;
    logic [S-1:0] fa, fb;
    logic za, zb, ia, ib, na, nb;
    logic s_q, nan_q, inf_q, zero_q;
    logic [E+1:0] e_q, ef;
    logic [PW-1:0] p_q, pn;
    logic [S:0] m;
    logic [S+1:0] mr;
    logic [S-1:0] fr;
    logic msb, g, st, up, cy, ovf, unf, sp;
    assign ea = a[W-2:S];
    assign eb = b[W-2:S];
    assign fa = a[S-1:0];
    assign fb = b[S-1:0];
    assign za = ea == '0;
    assign zb = eb == '0;
    assign ia = &ea && fa == '0;
    assign ib = &eb && fb == '0;
    assign na = &ea && fa != '0;
    assign nb = &eb && fb != '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= 1'b0;
            nan_q  <= 1'b0;
            inf_q  <= 1'b0;
            zero_q <= 1'b0;
            e_q    <= '0;
            p_q    <= '0;
        end else if (en) begin
            s_q    <= a[W-1] ^ b[W-1];
            nan_q  <= na | nb | (ia & zb) | (ib & za);
            inf_q  <= ia | ib;
            zero_q <= za | zb;
            e_q    <= {2'b00, ea} + {2'b00, eb} - (E+2)'(fp_bias(E));
            p_q    <= PW'({1'b1, fa}) * PW'({1'b1, fb});
        end
    end
    // Normalise so the leading one sits at the top; the shifted-out position decides the exponent bump.
    assign msb = p_q[PW-1];
    assign pn  = msb ? p_q : p_q << 1;
    assign m   = pn[PW-1:S+1];
    assign g   = pn[S];
    assign st  = |pn[S-1:0];
    assign up  = (RND_RNE != 0) && g && (st || m[0]);
    assign mr  = {1'b0, m} + (S+2)'(up);
    assign cy  = mr[S+1];
    assign fr  = cy ? mr[S:1] : mr[S-1:0];
    assign ef  = e_q + (E+2)'(msb) + (E+2)'(cy);
    assign ovf = !ef[E+1] && ef[E:0] >= (E+1)'((1 << E) - 1);
    assign unf = ef[E+1] || ef == '0;
    assign sp  = nan_q | inf_q | zero_q;
    assign z = nan_q  ? W'(fp_nan(S, E)) :
               inf_q  ? W'(fp_inf(S, E, s_q)) :
               zero_q ? {s_q, (W-1)'(0)} :
               ovf    ? W'(fp_inf(S, E, s_q)) :
               unf    ? {s_q, (W-1)'(0)} : {s_q, ef[E-1:0], fr};
    always_comb begin
        status         = '0;
        status[ST_INV] = nan_q;
        status[ST_OVF] = !sp && ovf;
        status[ST_UNF] = !sp && unf;
        status[ST_INX] = !sp && (g || st || ovf || unf);
    end
endmodule

// File: rtl/fp_mult_lanes_pipe.sv
// fp_mult_lanes_pipe: LANES independent FP multipliers behind one valid/ready handshake,
// STAGES register stages deep, whole pipe freezes while the output is stalled.
module fp_mult_lanes_pipe
    import fp_mult_lanes_pipe_pkg::*;
#(
    parameter int SIG_WIDTH = 23,
    parameter int EXP_WIDTH = 8,
    parameter int LANES     = 4,
    parameter int STAGES    = 3,
    parameter int RND_RNE   = 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [LANES*(SIG_WIDTH+EXP_WIDTH+1)-1:0]  a,
    input  logic [LANES*(SIG_WIDTH+EXP_WIDTH+1)-1:0]  b,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    output logic [LANES*(SIG_WIDTH+EXP_WIDTH+1)-1:0]  z,
    output logic [LANES*ST_W-1:0]                     status,
    output logic                                      out_valid,
    input  logic                                      out_ready
);
    localparam int W = SIG_WIDTH + EXP_WIDTH + 1;
    logic [STAGES:1] vld;
    logic adv;
    logic [LANES*W-1:0] z_c;
    logic [LANES*ST_W-1:0] st_c;
    logic [LANES*W-1:0] z_q [2:STAGES];
    logic [LANES*ST_W-1:0] st_q [2:STAGES];
    assign out_valid = vld[STAGES];
    assign adv       = !(out_valid && !out_ready);
    assign in_ready  = adv;
    assign z         = z_q[STAGES];
    assign status    = st_q[STAGES];
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        fp_mult_lane #(
            .SIG_WIDTH(SIG_WIDTH),
            .EXP_WIDTH(EXP_WIDTH),
            .RND_RNE  (RND_RNE)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (adv),
            .a     (a[k*W +: W]),
            .b     (b[k*W +: W]),
            .z     (z_c[k*W +: W]),
            .status(st_c[k*ST_W +: ST_W])
        );
    end
    // Stage 1 lives inside the lanes; stage 2 captures the packed result, later stages only delay it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 2; i <= STAGES; i++) begin
                z_q[i]  <= '0;
                st_q[i] <= '0;
            end
        end else if (adv) begin
            vld     <= {vld[STAGES-1:1], in_valid};
            z_q[2]  <= z_c;
            st_q[2] <= st_c;
            for (int i = 3; i <= STAGES; i++) begin
                z_q[i]  <= z_q[i-1];
                st_q[i] <= st_q[i-1];
            end
        end
    end
endmodule

// File: tb/tb_fp_mult_lanes_pipe.sv
// tb_fp_mult_lanes_pipe: random and directed checks of the lane multiplier pipe against an
// arithmetic reference model; a second 1-lane, 2-stage truncating instance covers RND_RNE=0.
module tb_fp_mult_lanes_pipe;
    logic clk = 1'b0;
    logic rst_n;
    logic [127:0] a, b, z;
    logic [15:0] status;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [31:0] ta, tb, t_z;
    logic [3:0] t_status;
    logic t_in_valid, t_in_ready, t_out_valid, t_out_ready;
    int n_checks = 0;
    int n_pass = 0;
    int n_out = 0;
    int t_n_out = 0;
    logic acc, tacc, ov_seen;
    logic [127:0] last_z;
    logic [15:0] last_st;
    logic [31:0] last_tz;
    logic [3:0] last_tst;
    logic [143:0] exp_q[$];
    logic [35:0] texp_q[$];

    always #5 clk = ~clk;

    fp_mult_lanes_pipe dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
        .z(z), .status(status), .out_valid(out_valid), .out_ready(out_ready)
    );

    fp_mult_lanes_pipe #(.LANES(1), .STAGES(2), .RND_RNE(0)) dut_t (
        .clk(clk), .rst_n(rst_n), .a(ta), .b(tb), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .z(t_z), .status(t_status), .out_valid(t_out_valid), .out_ready(t_out_ready)
    );

    // Exact integer product, then round by comparing the discarded remainder with half an ulp.
    function automatic logic [35:0] ref_mul(logic [31:0] x, logic [31:0] y, bit rne);
        int ex, ey, e, sh;
        longint mx, my, p, q, rem, half;
        bit s, nx, ny, ix, iy, zx, zy;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        mx = longint'(x[22:0]);
        my = longint'(y[22:0]);
        s = x[31] ^ y[31];
        nx = ex == 255 && mx != 0;
        ny = ey == 255 && my != 0;
        ix = ex == 255 && mx == 0;
        iy = ey == 255 && my == 0;
        zx = ex == 0;
        zy = ey == 0;
        if (nx || ny || (ix && zy) || (iy && zx)) return {32'h7FC00000, 4'b0001};
        if (ix || iy) return {s, 31'h7F800000, 4'b0000};
        if (zx || zy) return {s, 31'h0, 4'b0000};
        p = (mx + (64'sd1 << 23)) * (my + (64'sd1 << 23));
        sh = (p >= (64'sd1 << 47)) ? 24 : 23;
        e = ex + ey - 127 + sh - 23;
        q = p >> sh;
        rem = p - (q << sh);
        half = 64'sd1 << (sh - 1);
        if (rne && (rem > half || (rem == half && q[0]))) q = q + 1;
        if (q == (64'sd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 31'h7F800000, 4'b1010};
        if (e <= 0) return {s, 31'h0, 4'b1100};
        return {s, 8'(e), q[22:0], rem != 0, 3'b000};
    endfunction

    function automatic logic [143:0] ref_beat(logic [127:0] x, logic [127:0] y);
        logic [127:0] zz;
        logic [15:0] ss;
        logic [35:0] r;
        zz = '0;
        ss = '0;
        for (int k = 0; k < 4; k++) begin
            r = ref_mul(x[k*32 +: 32], y[k*32 +: 32], 1'b1);
            zz[k*32 +: 32] = r[35:4];
            ss[k*4 +: 4] = r[3:0];
        end
        return {zz, ss};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        int sel;
        r = $urandom;
        sel = $urandom_range(0, 15);
        if (sel == 0) r[30:0] = 31'h7F800000;
        else if (sel == 1) r[30:23] = 8'hFF;
        else if (sel == 2) r[30:23] = 8'h00;
        else if (sel == 3) r[30:23] = 8'($urandom_range(190, 254));
        else if (sel == 4) r[30:23] = 8'($urandom_range(1, 64));
        else r[30:23] = 8'($urandom_range(100, 154));
        return r;
    endfunction

    function automatic logic [127:0] rand_beat();
        return {rand_op(), rand_op(), rand_op(), rand_op()};
    endfunction

    task automatic chk(string tag, logic [159:0] obs, logic [159:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: handshakes are observed at the falling edge, inputs change just after the rising edge.
    task automatic tick();
        @(negedge clk);
        ov_seen = out_valid && out_ready;
        acc = in_valid && in_ready;
        tacc = t_in_valid && t_in_ready;
        if (ov_seen) begin
            n_out++;
            last_z = z;
            last_st = status;
            if (exp_q.size() == 0) chk("spurious_out", out_valid, 1'b0);
            else chk("beat", {z, status}, exp_q.pop_front());
        end
        if (t_out_valid && t_out_ready) begin
            t_n_out++;
            last_tz = t_z;
            last_tst = t_status;
            if (texp_q.size() == 0) chk("t_spurious_out", t_out_valid, 1'b0);
            else chk("t_beat", {t_z, t_status}, texp_q.pop_front());
        end
        if (acc) exp_q.push_back(ref_beat(a, b));
        if (tacc) texp_q.push_back(ref_mul(ta, tb, 1'b0));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        t_in_valid = 1'b0;
        out_ready = 1'b1;
        t_out_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || texp_q.size() != 0); i++) tick();
        chk("drain_timeout", exp_q.size() + texp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, sent, n0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        t_in_valid = 1'b0;
        t_out_ready = 1'b1;
        ta = '0;
        tb = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_z", z, 128'h0);
        chk("rst_status", status, 16'h0);
        chk("rst_t_z", {t_z, t_status, t_out_valid}, 37'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // 1.5 * 2.0 on lane 0 and its latency
        a = {rand_op(), rand_op(), rand_op(), 32'h3FC00000};
        b = {rand_op(), rand_op(), rand_op(), 32'h40000000};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("accept", acc, 1'b1);
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            tick();
            if (ov_seen) lat = i;
        end
        chk("latency", lat, 3);
        chk("z0_3x2", last_z[31:0], 32'h40400000);
        chk("st0_3x2", last_st[3:0], 4'h0);
        drain();

        // inexact, overflow, underflow and invalid lanes; truncating instance on the same inexact case
        a = {32'h7F800000, 32'h00800000, 32'h7F000000, 32'h3F800001};
        b = {32'h00000000, 32'h00800000, 32'h7F000000, 32'h3F800001};
        ta = 32'h3F800001;
        tb = 32'h3F800001;
        in_valid = 1'b1;
        t_in_valid = 1'b1;
        tick();
        drain();
        chk("z_inexact", {last_z[31:0], last_st[3:0]}, {32'h3F800002, 4'b1000});
        chk("z_overflow", {last_z[63:32], last_st[7:4]}, {32'h7F800000, 4'b1010});
        chk("z_underflow", {last_z[95:64], last_st[11:8]}, {32'h00000000, 4'b1100});
        chk("z_invalid", {last_z[127:96], last_st[15:12]}, {32'h7FC00000, 4'b0001});
        chk("t_inexact", {last_tz, last_tst}, {32'h3F800002, 4'b1000});

        // ties to even (up and down), signed zero, signed infinity
        a = {32'hC0000000, 32'h80000000, 32'h3F800003, 32'h3F800001};
        b = {32'h7F800000, 32'h3F800000, 32'h3FC00000, 32'h3FC00000};
        ta = 32'h3F800001;
        tb = 32'h3FC00000;
        in_valid = 1'b1;
        t_in_valid = 1'b1;
        tick();
        drain();
        chk("tie_up", {last_z[31:0], last_st[3:0]}, {32'h3FC00002, 4'b1000});
        chk("tie_even", {last_z[63:32], last_st[7:4]}, {32'h3FC00004, 4'b1000});
        chk("neg_zero", {last_z[95:64], last_st[11:8]}, {32'h80000000, 4'b0000});
        chk("neg_inf", {last_z[127:96], last_st[15:12]}, {32'hFF800000, 4'b0000});
        chk("t_trunc", {last_tz, last_tst}, {32'h3FC00001, 4'b1000});

        // 10-beat stream with the output stalled for cycles 4..7
        n0 = n_out;
        sent = 0;
        a = rand_beat();
        b = rand_beat();
        in_valid = 1'b1;
        for (int i = 0; i < 40 && sent < 10; i++) begin
            out_ready = !(i >= 4 && i <= 7);
            #1;
            chk("stall_in_ready", in_ready, (i >= 4 && i <= 7) ? 1'b0 : 1'b1);
            tick();
            if (acc) begin
                sent++;
                a = rand_beat();
                b = rand_beat();
            end
        end
        drain();
        chk("stream_count", n_out - n0, 10);

        // reset with three beats in flight
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = rand_beat();
            b = rand_beat();
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 1'b0);
        chk("rst_async_z", {z, status}, 144'h0);
        chk("rst_async_ready", in_ready, 1'b1);
        exp_q.delete();
        texp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_idle", out_valid, 1'b0);
        end

        // random traffic with random backpressure on both instances
        for (int i = 0; i < 120; i++) begin
            a = rand_beat();
            b = rand_beat();
            ta = rand_op();
            tb = rand_op();
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            t_in_valid = $urandom_range(0, 3) != 0;
            t_out_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
